// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage data-access path.
//   - access size encodings
//   - MEM-stage FSM state encoding
//   - byte_enables(): maps an access size and the low address bits to the
//     four little-endian byte lanes. It returns 4'b0000 for every misaligned
//     or reserved access, so callers treat "no lanes" as an alignment error.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[0] ? 4'b0000 : (addr_lo[1] ? 4'b1100 : 4'b0011);
            SZ_WORD: be = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_ram_be.sv
// Single-port word RAM with per-byte write enables.
//   clk   : write clock (rising edge)
//   we    : byte-lane write enables, bit i writes wdata[8i+7:8i]
//   addr  : word index
//   wdata : write data (already placed on the correct lanes)
//   rdata : combinational read of the word at addr
// Contents are not reset.
module data_ram_be #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_data_access.sv
// MEM pipeline stage: either passes an ALU result straight to WB, or
// performs a byte/half/word load or store against a local data RAM after a
// programmable number of wait states, stalling EXE meanwhile.
//   clk, rst_n            : clock, asynchronous active-low reset
//   ex_valid/ex_ls/ex_load: request from EXE (ls=1 memory op, load=1 read)
//   ex_size/ex_addr       : access size and address (or ALU result)
//   ex_wdata/ex_rd        : store data and destination register
//   stall                 : EXE must hold its request while high
//   wb_valid/wb_we/align_err : single-cycle result pulses to WB
//   wb_rd/wb_data         : result register index and value (held)
module mem_stage_data_access
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_ls,
    input  logic        ex_load,
    input  logic [1:0]  ex_size,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_rd,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        align_err
);

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic        align_err_q, align_err_d;
    logic [3:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    // Request latch: data only, so it carries no reset.
    logic              req_load_q, req_load_d;
    logic [1:0]        req_size_q, req_size_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]       req_wdata_q, req_wdata_d;
    logic [3:0]        req_rd_q, req_rd_d;

    logic [3:0]  be;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] load_data;

    assign be = byte_enables(req_size_q, req_addr_q[1:0]);

    // Replicate the store data across lanes; the byte enables pick the lanes.
    always_comb begin
        ram_wdata = req_wdata_q;
        case (req_size_q)
            SZ_BYTE: ram_wdata = {4{req_wdata_q[7:0]}};
            SZ_HALF: ram_wdata = {2{req_wdata_q[15:0]}};
            default: ram_wdata = req_wdata_q;
        endcase
    end

    // Zero-extended load extraction from the addressed lanes.
    always_comb begin
        load_data = ram_rdata;
        case (req_size_q)
            SZ_BYTE: load_data = {24'd0, 8'(ram_rdata >> {req_addr_q[1:0], 3'b000})};
            SZ_HALF: load_data = {16'd0, req_addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0]};
            default: load_data = ram_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        align_err_d = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        ram_we      = 4'b0000;
        req_load_d  = req_load_q;
        req_size_d  = req_size_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_rd_d    = req_rd_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid && !ex_ls) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = 1'b1;
                    wb_data_d  = ex_addr;
                    wb_rd_d    = ex_rd;
                end else if (ex_valid && ex_ls) begin
                    req_load_d  = ex_load;
                    req_size_d  = ex_size;
                    req_addr_d  = ex_addr[ADDR_W-1:0];
                    req_wdata_d = ex_wdata;
                    req_rd_d    = ex_rd;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                state_d    = ST_IDLE;
                wb_valid_d = 1'b1;
                wb_rd_d    = req_rd_q;
                if (be == 4'b0000) begin
                    align_err_d = 1'b1;
                    wb_data_d   = 32'd0;
                end else if (req_load_q) begin
                    wb_we_d   = 1'b1;
                    wb_data_d = load_data;
                end else begin
                    ram_we    = be;
                    wb_data_d = 32'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            align_err_q <= 1'b0;
            wb_rd_q     <= 4'd0;
            wb_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            align_err_q <= align_err_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    always_ff @(posedge clk) begin
        req_load_q  <= req_load_d;
        req_size_q  <= req_size_d;
        req_addr_q  <= req_addr_d;
        req_wdata_q <= req_wdata_d;
        req_rd_q    <= req_rd_d;
    end

    data_ram_be #(.AW(ADDR_W - 2)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (req_addr_q[ADDR_W-1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign stall     = (state_q != ST_IDLE);
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign align_err = align_err_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;

endmodule
